// File: rtl/temp_conv_pkg.sv
// temp_conv_pkg: shared state type, constants and width helpers
// for the Celsius-to-Fahrenheit conversion scheduler.
package temp_conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        ADD,
        RESP
    } state_t;

    localparam int F_OFFSET = 32;
    localparam int MUL_K    = 9;
    localparam int DIV_K    = 5;
    // MUL_K = (1 << MUL_SH) + 1, so the product is one shift and one add
    localparam int MUL_SH   = $clog2(MUL_K) - 1;

    function automatic int div_steps(input int cw);
        return cw + 4;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching cyclically
// from pointer+1. The pointer register is owned by the parent.
module rr_arbiter
    import temp_conv_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDW = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDW-1:0] idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(pointer) + k) % NUM_REQ);
            if (enable && req[idx])
                grant = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/temp_conv_scheduler.sv
// temp_conv_scheduler: round-robin shared C->F engine, F = floor(C*9/5)+32.
// Define TEMP_CONV_ROUND_EN for round-half-up on the division.
module temp_conv_scheduler
    import temp_conv_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CW      = 8,
    parameter int FW      = 16,
    localparam int IDW    = id_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*CW-1:0] req_celsius,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [FW-1:0]         resp_fahrenheit,
    output logic                  busy
);

    localparam int PW   = div_steps(CW);
    localparam int CNTW = $clog2(PW);

    state_t              state;
    state_t              state_n;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      gnt_id;
    logic [IDW-1:0]      id_q;
    logic [CW-1:0]       c_q;
    logic [PW-1:0]       acc;
    logic [2:0]          rem;
    logic [CNTW-1:0]     cnt;
    logic [NUM_REQ-1:0]  grant;
    logic                hs;
    logic [3:0]          trial;
    logic                q_bit;
    logic [2:0]          rem_n;
    logic [FW-1:0]       f_sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr),
        .enable  ((state == IDLE) && !rst),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign busy      = (state != IDLE);

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i])
                gnt_id = IDW'(i);
    end

    // acc holds the dividend shifting out MSB-first and the
    // quotient shifting in at the bottom.
    always_comb begin
        trial = {rem, acc[PW-1]};
        q_bit = (trial >= 4'(DIV_K));
        rem_n = q_bit ? 3'(trial - 4'(DIV_K)) : trial[2:0];
    end

    always_comb begin
        f_sum = FW'(acc) + FW'(F_OFFSET);
`ifdef TEMP_CONV_ROUND_EN
        if (rem >= 3'd3)
            f_sum = f_sum + FW'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (hs) state_n = MUL;
            MUL:     state_n = DIV;
            DIV:     if (cnt == CNTW'(PW - 1)) state_n = ADD;
            ADD:     state_n = RESP;
            RESP:    if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= IDW'(NUM_REQ - 1);
            id_q            <= '0;
            c_q             <= '0;
            acc             <= '0;
            rem             <= '0;
            cnt             <= '0;
            resp_valid      <= 1'b0;
            resp_id         <= '0;
            resp_fahrenheit <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        ptr  <= gnt_id;
                        id_q <= gnt_id;
                        c_q  <= req_celsius[gnt_id*CW +: CW];
                    end
                end
                MUL: begin
                    acc <= (PW'(c_q) << MUL_SH) + PW'(c_q);
                    rem <= '0;
                    cnt <= '0;
                end
                DIV: begin
                    acc <= {acc[PW-2:0], q_bit};
                    rem <= rem_n;
                    cnt <= cnt + CNTW'(1);
                end
                ADD: begin
                    resp_valid      <= 1'b1;
                    resp_id         <= id_q;
                    resp_fahrenheit <= f_sum;
                end
                RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_conv_scheduler.sv
// tb_temp_conv_scheduler: directed table vectors plus hand-written
// sequences for back-pressure, reset mid-conversion and round-robin order.
module tb_temp_conv_scheduler;

    localparam int NUM_REQ = 3;
    localparam int CW      = 8;
    localparam int FW      = 16;
    localparam int IDW     = 2;
    localparam int NV      = 10;

`ifdef TEMP_CONV_ROUND_EN
    localparam int F37 = 99;
`else
    localparam int F37 = 98;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*CW-1:0] req_celsius;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [FW-1:0]         resp_fahrenheit;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int id;
        int c;
        int f_trunc;
        int f_round;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    temp_conv_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CW      (CW),
        .FW      (FW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_celsius     (req_celsius),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_fahrenheit (resp_fahrenheit),
        .busy            (busy)
    );

    function automatic void check(input string name, input int act,
                                  input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int exp_f(input vec_t v);
`ifdef TEMP_CONV_ROUND_EN
        return v.f_round;
`else
        return v.f_trunc;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid, wait for the grant, let the handshake edge pass.
    task automatic request(input int id, input int c, output bit ok);
        req_celsius[id*CW +: CW] = CW'(c);
        req_valid[id] = 1'b1;
        #1;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (req_ready[id])
                ok = 1'b1;
            tick();
        end
        req_valid[id] = 1'b0;
    endtask

    // lat = cycle index (handshake cycle = 0) where resp_valid is first seen
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    bit             ok;
    int             lat;
    int             g;
    bit             stable;
    bit             rdy_zero;
    bit             seen;
    bit             multi;
    bit             busy_ok;
    logic [IDW-1:0] rid0;
    logic [FW-1:0]  rf0;
    int             rr_order [4];
    int             rr_f [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{0,   0,  32,  32};
        vecs[1] = '{1, 100, 212, 212};
        vecs[2] = '{1, 255, 491, 491};
        vecs[3] = '{2,  37,  98,  99};
        vecs[4] = '{0,   1,  33,  34};
        vecs[5] = '{2,  20,  68,  68};
        vecs[6] = '{1,   2,  35,  36};
        vecs[7] = '{0,   4,  39,  39};
        vecs[8] = '{2,  50, 122, 122};
        vecs[9] = '{0, 200, 392, 392};
        rr_order = '{0, 1, 2, 0};
        rr_f     = '{32, 212, 491};

        rst         = 1'b1;
        req_valid   = '0;
        req_celsius = '0;
        resp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_id", int'(resp_id), 0);
        check("rst_resp_f", int'(resp_fahrenheit), 0);
        check("rst_busy", int'(busy), 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            request(vecs[i].id, vecs[i].c, ok);
            check($sformatf("v%0d_grant", i), int'(ok), 1);
            wait_resp(lat);
            check($sformatf("v%0d_latency", i), lat, 15);
            check($sformatf("v%0d_resp_id", i), int'(resp_id), vecs[i].id);
            check($sformatf("v%0d_resp_f", i), int'(resp_fahrenheit),
                  exp_f(vecs[i]));
            accept();
            check($sformatf("v%0d_resp_drop", i), int'(resp_valid), 0);
            check($sformatf("v%0d_idle", i), int'(busy), 0);
        end

        // Back-pressure: hold resp_ready low for 10 cycles
        request(0, 37, ok);
        wait_resp(lat);
        check("stall_latency", lat, 15);
        rid0 = resp_id;
        rf0  = resp_fahrenheit;
        check("stall_f", int'(rf0), F37);
        req_celsius[1*CW +: CW] = 8'd50;
        req_valid[1] = 1'b1;
        stable   = 1'b1;
        rdy_zero = 1'b1;
        repeat (10) begin
            if (!resp_valid || resp_id != rid0 || resp_fahrenheit != rf0)
                stable = 1'b0;
            if (req_ready != '0)
                rdy_zero = 1'b0;
            tick();
        end
        check("stall_stable", int'(stable), 1);
        check("stall_ready_low", int'(rdy_zero), 1);
        resp_ready = 1'b1;
        #1;
        check("accept_cycle_ready", int'(req_ready), 0);
        tick();
        resp_ready = 1'b0;
        check("post_accept_valid", int'(resp_valid), 0);
        check("post_accept_grant", int'(req_ready), 2);
        tick();
        req_valid[1] = 1'b0;
        wait_resp(lat);
        check("pend_latency", lat, 15);
        check("pend_resp_id", int'(resp_id), 1);
        check("pend_resp_f", int'(resp_fahrenheit), 122);
        accept();

        // Reset in the middle of DIV
        request(2, 255, ok);
        check("rst_mid_grant", int'(ok), 1);
        repeat (5) tick();
        check("rst_mid_busy_pre", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_valid", int'(resp_valid), 0);
        rst = 1'b0;
        tick();
        seen = 1'b0;
        repeat (20) begin
            if (resp_valid)
                seen = 1'b1;
            tick();
        end
        check("rst_mid_no_resp", int'(seen), 0);
        check("rst_mid_idle", int'(busy), 0);
        req_celsius[0*CW +: CW] = 8'd20;
        req_celsius[2*CW +: CW] = 8'd20;
        req_valid = 3'b101;
        #1;
        check("rst_mid_prio", int'(req_ready), 1);
        tick();
        req_valid = '0;
        wait_resp(lat);
        check("rst_mid_latency", lat, 15);
        check("rst_mid_resp_id", int'(resp_id), 0);
        check("rst_mid_resp_f", int'(resp_fahrenheit), 68);
        accept();

        // Round-robin with all requesters held valid
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        req_celsius[0*CW +: CW] = 8'd0;
        req_celsius[1*CW +: CW] = 8'd100;
        req_celsius[2*CW +: CW] = 8'd255;
        req_valid = 3'b111;
        #1;
        for (int r = 0; r < 4; r++) begin
            g = -1;
            multi = 1'b0;
            for (int k = 0; k < 64 && g < 0; k++) begin
                if (req_ready != '0) begin
                    multi = !$onehot(req_ready);
                    for (int i = 0; i < NUM_REQ; i++)
                        if (req_ready[i] && g < 0)
                            g = i;
                end else begin
                    tick();
                end
            end
            check($sformatf("rr%0d_onehot", r), int'(multi), 0);
            check($sformatf("rr%0d_order", r), g, rr_order[r]);
            tick();
            busy_ok = 1'b1;
            lat = 1;
            while (!resp_valid && lat < 64) begin
                if (req_ready != '0)
                    busy_ok = 1'b0;
                tick();
                lat++;
            end
            check($sformatf("rr%0d_busy_ready", r), int'(busy_ok), 1);
            check($sformatf("rr%0d_latency", r), lat, 15);
            check($sformatf("rr%0d_resp_id", r), int'(resp_id), rr_order[r]);
            check($sformatf("rr%0d_resp_f", r), int'(resp_fahrenheit),
                  rr_f[rr_order[r]]);
            accept();
        end
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
